// File: rtl/instr_issue_sequencer.sv
// ---------------------------------------------------------------------------
// instr_issue_sequencer
//   Feeds 32-bit R-type instruction words, one per cycle, to a DataPath
//   instruction port. The host fills an internal FIFO over valid/ready. An
//   IDLE/RUN/STEP state machine drains the FIFO. When the head word reads
//   the register written by the word now on the output, one NOP bubble is
//   inserted before it issues.
//
// Ports
//   CLK, RST      clock (rising edge), asynchronous active-high reset
//   in_valid      host presents in_instr
//   in_instr      word to enqueue
//   in_ready      FIFO has room (combinational from fifo_count)
//   start         enter RUN
//   step          issue exactly one word, then return to IDLE
//   halt          return to IDLE (priority halt > step > start)
//   instruction   issued word, or 32'h0 (NOP)
//   issue_valid   instruction carries a real issued word this cycle
//   busy          state != IDLE
//   fifo_count    words currently queued
//   issued_count  total words issued, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module instr_issue_sequencer #(
    parameter int DEPTH  = 8,   // power of 2, >= 2
    parameter int CNT_W  = 16,
    parameter int HAZ_EN = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    input  logic                     start,
    input  logic                     step,
    input  logic                     halt,
    output logic [31:0]              instruction,
    output logic                     issue_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         issued_count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

    state_t         state, state_nxt;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [31:0]    head;
    logic [4:0]     prev_rd;
    logic           push, pop, empty, hazard;

    // ---------------- FIFO ----------------
    // in_ready looks only at the current count, so a pop in the same cycle
    // never lets a push into a full FIFO.
    assign in_ready = (fifo_count < FULL_CNT);
    assign push     = in_valid && in_ready;
    assign empty    = (fifo_count == '0);
    assign head     = mem[rd_ptr];

    // Storage needs no reset; the pointers/count define what is valid.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- RAW hazard ----------------
    // Only an R-type head following a real R-type issue with a nonzero rd
    // can stall. Because the bubble clears issue_valid, the stall lasts
    // exactly one cycle.
    assign prev_rd = instruction[15:11];
    assign hazard  = (HAZ_EN != 0) && !empty
                  && (head[31:26] == 6'd0)
                  && issue_valid && (instruction[31:26] == 6'd0)
                  && (prev_rd != 5'd0)
                  && ((head[25:21] == prev_rd) || (head[20:16] == prev_rd));

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (halt)       state_nxt = S_IDLE;
                else if (step)  state_nxt = S_STEP;
                else if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt)                  state_nxt = S_IDLE;
                else if (!empty && !hazard) pop      = 1'b1;
            end
            S_STEP: begin
                // Empty FIFO or a bubble keeps us waiting in STEP.
                if (halt) begin
                    state_nxt = S_IDLE;
                end else if (!empty && !hazard) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Output register ----------------
    // Every edge without a pop (IDLE, empty, bubble, halt) loads a NOP,
    // which also drops any word left over from the previous cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instruction  <= '0;
            issue_valid  <= 1'b0;
            busy         <= 1'b0;
            issued_count <= '0;
        end else begin
            instruction <= pop ? head : 32'h0;
            issue_valid <= pop;
            busy        <= (state_nxt != S_IDLE);
            if (pop)
                issued_count <= issued_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
module tb_instr_issue_sequencer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic                      CLK = 1'b0;
    logic                      RST;
    logic                      in_valid, start, step, halt;
    logic [31:0]               in_instr;
    logic                      in_ready, issue_valid, busy;
    logic [31:0]               instruction;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic [CNT_W-1:0]          issued_count;

    // second instance with hazard detection disabled
    logic                      in_valid2, start2, step2, halt2;
    logic [31:0]               in_instr2;
    logic                      in_ready2, issue_valid2, busy2;
    logic [31:0]               instruction2;
    logic [$clog2(DEPTH):0]    fifo_count2;
    logic [CNT_W-1:0]          issued_count2;

    always #5 CLK = ~CLK;

    instr_issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .HAZ_EN(1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .start(start), .step(step), .halt(halt),
        .instruction(instruction), .issue_valid(issue_valid), .busy(busy),
        .fifo_count(fifo_count), .issued_count(issued_count)
    );

    instr_issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .HAZ_EN(0)) dut_nohaz (
        .CLK(CLK), .RST(RST), .in_valid(in_valid2), .in_instr(in_instr2),
        .in_ready(in_ready2), .start(start2), .step(step2), .halt(halt2),
        .instruction(instruction2), .issue_valid(issue_valid2), .busy(busy2),
        .fifo_count(fifo_count2), .issued_count(issued_count2)
    );

    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic [31:0]   exp_q[$];
    logic [3:0]    exp_iss = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard: record accepted words, compare each issued word in order
    always @(posedge CLK)
        if (!RST && in_valid && in_ready) exp_q.push_back(in_instr);

    always @(negedge CLK)
        if (!RST && issue_valid) begin
            if (exp_q.size() == 0) chk("sb_extra", 32'(issue_valid), 32'd0);
            else                   chk("sb_issue", instruction, exp_q.pop_front());
            exp_iss = exp_iss + 4'd1;
        end

    task automatic push_word(input logic [31:0] w);
        in_valid = 1'b1; in_instr = w;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic push_word2(input logic [31:0] w);
        in_valid2 = 1'b1; in_instr2 = w;
        @(negedge CLK);
        in_valid2 = 1'b0;
    endtask

    initial begin
        int guard;
        RST = 1'b1;
        in_valid = 0; in_instr = '0; start = 0; step = 0; halt = 0;
        in_valid2 = 0; in_instr2 = '0; start2 = 0; step2 = 0; halt2 = 0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_instr", instruction, 32'h0);
        chk("rst_iv", 32'(issue_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        RST = 1'b0;

        // T1: reset mid-RUN with 3 queued
        push_word(32'h00012020);
        push_word(32'h00222822);
        push_word(32'h0043302A);
        start = 1'b1; @(negedge CLK); start = 1'b0;
        chk("t1_busy_pre", 32'(busy), 32'd1);
        chk("t1_cnt_pre", 32'(fifo_count), 32'd3);
        RST = 1'b1; exp_q.delete(); exp_iss = '0;
        #1;
        chk("t1_instr", instruction, 32'h0);
        chk("t1_iv", 32'(issue_valid), 32'd0);
        chk("t1_cnt", 32'(fifo_count), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_issued", 32'(issued_count), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // T2: three back-to-back issues then NOP, still RUN
        push_word(32'h00012020);
        push_word(32'h00222822);
        push_word(32'h0043302A);
        start = 1'b1; @(negedge CLK); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t2_iv", 32'(issue_valid), 32'd1);
        end
        @(negedge CLK);
        chk("t2_nop_iv", 32'(issue_valid), 32'd0);
        chk("t2_nop", instruction, 32'h0);
        chk("t2_issued", 32'(issued_count), 32'd3);
        chk("t2_busy", 32'(busy), 32'd1);
        halt = 1'b1; @(negedge CLK); halt = 1'b0;
        chk("t2_halt_busy", 32'(busy), 32'd0);

        // T3: RAW hazard inserts one bubble
        push_word(32'h00012020);
        push_word(32'h00852822);
        start = 1'b1; @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        chk("t3_w0", instruction, 32'h00012020);
        @(negedge CLK);
        chk("t3_bub_iv", 32'(issue_valid), 32'd0);
        chk("t3_bub", instruction, 32'h0);
        @(negedge CLK);
        chk("t3_w1", instruction, 32'h00852822);
        chk("t3_w1_iv", 32'(issue_valid), 32'd1);
        halt = 1'b1; @(negedge CLK); halt = 1'b0;

        // T3b: same pair without hazard detection -> no bubble
        push_word2(32'h00012020);
        push_word2(32'h00852822);
        start2 = 1'b1; @(negedge CLK); start2 = 1'b0;
        @(negedge CLK);
        chk("t3b_w0", instruction2, 32'h00012020);
        @(negedge CLK);
        chk("t3b_w1", instruction2, 32'h00852822);
        chk("t3b_w1_iv", 32'(issue_valid2), 32'd1);
        halt2 = 1'b1; @(negedge CLK); halt2 = 1'b0;

        // T4: step issues exactly one word per pulse
        push_word(32'h00012020);
        push_word(32'h00222822);
        push_word(32'h0043302A);
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; @(negedge CLK); step = 1'b0;
            chk("t4_busy_step", 32'(busy), 32'd1);
            @(negedge CLK);
            chk("t4_iv", 32'(issue_valid), 32'd1);
            chk("t4_busy_idle", 32'(busy), 32'd0);
            chk("t4_cnt", 32'(fifo_count), 32'(2 - s));
            @(negedge CLK);
            chk("t4_idle_iv", 32'(issue_valid), 32'd0);
        end

        // T5: fill, reject extra push, then push-per-pop steady state
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_instr = 32'h8C00_0000 | 32'(i);
            @(negedge CLK);
        end
        in_instr = 32'hDEADBEEF;
        @(negedge CLK);
        chk("t5_ready", 32'(in_ready), 32'd0);
        chk("t5_full", 32'(fifo_count), 32'(DEPTH));
        in_instr = 32'h8C10_0000;
        start = 1'b1; @(negedge CLK); start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in_instr = 32'h8C10_0000 + 32'(k);
            @(negedge CLK);
            chk("t5_steady", 32'(fifo_count), 32'(DEPTH - 1));
            chk("t5_iv", 32'(issue_valid), 32'd1);
        end
        in_valid = 1'b0;
        repeat (10) @(negedge CLK);
        chk("t5_drained", 32'(fifo_count), 32'd0);
        chk("t5_issued", 32'(issued_count), 32'(exp_iss));

        // T6: counter wrap (still in RUN)
        guard = 0;
        while (exp_iss != 4'hF && guard < 40) begin
            push_word(32'h2000_0000 | 32'(guard));
            @(negedge CLK);
            @(negedge CLK);
            guard++;
        end
        chk("t6_pre_wrap", 32'(issued_count), 32'h0000_000F);
        push_word(32'h2000_0ABC);
        @(negedge CLK);
        chk("t6_wrap", 32'(issued_count), 32'd0);
        @(negedge CLK);

        // T6: halt+step+start together in RUN with a word queued
        in_valid = 1'b1; in_instr = 32'h00A1_5820;
        @(negedge CLK);
        in_valid = 1'b0;
        halt = 1'b1; step = 1'b1; start = 1'b1;
        @(negedge CLK);
        halt = 1'b0; step = 1'b0; start = 1'b0;
        chk("t6_prio_busy", 32'(busy), 32'd0);
        chk("t6_prio_iv", 32'(issue_valid), 32'd0);
        chk("t6_prio_cnt", 32'(fifo_count), 32'd1);
        chk("t6_prio_issued", 32'(issued_count), 32'd0);
        @(negedge CLK);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        step = 1'b1; @(negedge CLK); step = 1'b0;
        @(negedge CLK);
        chk("t6_step_cnt", 32'(fifo_count), 32'd0);
        chk("t6_step_issued", 32'(issued_count), 32'd1);
        @(negedge CLK);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
